sram_bus_arbiter: RTL

- Two-master, one-slave arbiter that shares the single external SRAM port between the TTA instruction-side and data-side buses.
- Sits between the core's bus masters and the board-level SRAM pins.
- Uses round-robin on contention and locks the grant for a whole valid/ready transaction.
- A bus watchdog completes hung transactions with an error word so the core cannot stall forever.

---
 rtl/sram_bus_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
// Round-robin arbiter sharing one SRAM port between two valid/ready masters.
// The grant is held for a whole transaction; a watchdog ends hung transfers with ERR_DATA.
module sram_bus_arbiter #(
  parameter int ADDR_WIDTH     = 19,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      m0_valid_i,
  input  logic [31:0]               m0_addr_i,
  input  logic [DATA_WIDTH/8-1:0]   m0_wstrb_i,
  input  logic [DATA_WIDTH-1:0]     m0_write_data_i,
  output logic [DATA_WIDTH-1:0]     m0_read_data_o,
  output logic                      m0_ready_o,

  input  logic                      m1_valid_i,
  input  logic [31:0]               m1_addr_i,
  input  logic [DATA_WIDTH/8-1:0]   m1_wstrb_i,
  input  logic [DATA_WIDTH-1:0]     m1_write_data_i,
  output logic [DATA_WIDTH-1:0]     m1_read_data_o,
  output logic                      m1_ready_o,

  output logic                      s_valid_o,
  output logic [ADDR_WIDTH-1:0]     s_addr_o,
  output logic [DATA_WIDTH/8-1:0]   s_wstrb_o,
  output logic [DATA_WIDTH-1:0]     s_write_data_o,
  input  logic [DATA_WIDTH-1:0]     s_read_data_i,
  input  logic                      s_ready_i,

  output logic [1:0]                grant_o,
  output logic                      timeout_o,
  output logic                      timeout_master_o
);

  localparam int  CW          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit  WATCHDOG_ON = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] LAST_COUNT = WATCHDOG_ON ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t          state, state_next;
  logic            last_grant, last_grant_next;
  logic [CW-1:0]   count, count_next;
  logic            timeout_next, timeout_master_next;

  logic                  owner;
  logic                  granted;
  logic                  expire;
  logic                  owner_ready;
  logic [DATA_WIDTH-1:0] owner_data;

  // Address bits above the SRAM range are deliberately discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr_i[31:ADDR_WIDTH], m1_addr_i[31:ADDR_WIDTH]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      count            <= '0;
      timeout_o        <= 1'b0;
      timeout_master_o <= 1'b0;
    end else begin
      state            <= state_next;
      last_grant       <= last_grant_next;
      count            <= count_next;
      timeout_o        <= timeout_next;
      timeout_master_o <= timeout_master_next;
    end
  end

  always_comb begin
    state_next          = state;
    last_grant_next     = last_grant;
    count_next          = count;
    timeout_next        = timeout_o;
    timeout_master_next = timeout_master_o;

    owner   = (state == GRANT1);
    granted = (state == GRANT0) || (state == GRANT1);
    // A real slave completion on the expiry cycle takes precedence over the watchdog.
    expire  = WATCHDOG_ON && granted && !s_ready_i && (count == LAST_COUNT);

    owner_ready = s_ready_i | expire;
    owner_data  = expire ? ERR_DATA : s_read_data_i;

    s_valid_o      = granted;
    s_addr_o       = owner ? m1_addr_i[ADDR_WIDTH-1:0] : m0_addr_i[ADDR_WIDTH-1:0];
    s_wstrb_o      = owner ? m1_wstrb_i : m0_wstrb_i;
    s_write_data_o = owner ? m1_write_data_i : m0_write_data_i;

    m0_ready_o     = (state == GRANT0) && owner_ready;
    m0_read_data_o = (state == GRANT0) ? owner_data : '0;
    m1_ready_o     = (state == GRANT1) && owner_ready;
    m1_read_data_o = (state == GRANT1) ? owner_data : '0;
    grant_o        = {state == GRANT1, state == GRANT0};

    case (state)
      IDLE: begin
        count_next = '0;
        if (m0_valid_i && m1_valid_i) begin
          state_next = last_grant ? GRANT0 : GRANT1;
        end else if (m0_valid_i) begin
          state_next = GRANT0;
        end else if (m1_valid_i) begin
          state_next = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (owner_ready) begin
          state_next      = IDLE;
          last_grant_next = owner;
          count_next      = '0;
          if (expire) begin
            timeout_next        = 1'b1;
            timeout_master_next = owner;
          end
        end else begin
          count_next = count + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

endmodule
